// File: rtl/mbox_pkg.sv
// Shared types and address-map helpers for the mailbox queue hub.
// Address map: pop queues, then per-CPU status words, then per-source drop counters.
package mbox_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_RESP,
    ST_HOLD
  } rd_state_e;

  typedef enum logic [1:0] {
    REG_POP,
    REG_STATUS,
    REG_DROP,
    REG_BAD
  } region_e;

  localparam int unsigned POP_BASE = 0;

  function automatic int unsigned status_base(input int unsigned n);
    return n * n;
  endfunction

  function automatic int unsigned drop_base(input int unsigned n);
    return n * n + n;
  endfunction

  function automatic region_e addr_region(input logic [31:0] addr, input int unsigned n);
    if (addr < status_base(n))
      return REG_POP;
    else if (addr < drop_base(n))
      return REG_STATUS;
    else if (addr < drop_base(n) + n)
      return REG_DROP;
    else
      return REG_BAD;
  endfunction

  // Offset inside the region: queue index for pops, CPU/source index otherwise.
  function automatic logic [31:0] addr_offset(input logic [31:0] addr, input int unsigned n);
    case (addr_region(addr, n))
      REG_POP:    return addr - POP_BASE;
      REG_STATUS: return addr - status_base(n);
      REG_DROP:   return addr - drop_base(n);
      default:    return '0;
    endcase
  endfunction

  function automatic logic [31:0] q_index(input logic [31:0] dst, input logic [31:0] src,
                                          input int unsigned n);
    return dst * n + src;
  endfunction

endpackage

// File: rtl/mbox_fifo_ctrl.sv
// One DEPTH-entry message queue: pointers, occupancy count, full/empty and storage.
// Pushes into a full queue and pops from an empty one are ignored here.
module mbox_fifo_ctrl #(
  parameter int DEPTH       = 4,
  parameter int W_WIDTH_SYS = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W_WIDTH_SYS-1:0] wr_data,
  output logic [W_WIDTH_SYS-1:0] rd_data,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W_WIDTH_SYS-1:0] mem [DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic                   do_push;
  logic                   do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mbox_queue_hub.sv
// Mailbox hub: N*N message queues filled by a valid/ready port, popped over a req/ack bus.
// Optional MBOX_DROP_CNT_EN: full-queue writes are accepted, discarded and counted per source.
module mbox_queue_hub
  import mbox_pkg::*;
#(
  parameter int N_NUMB_CPU  = 4,
  parameter int DEPTH       = 4,
  parameter int W_WIDTH_SYS = 32,
  parameter int WIDTH_ADDR  = 8,
  parameter int HOLD_CYC    = 3
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          wr_valid_i,
  output logic                          wr_ready_o,
  input  logic [$clog2(N_NUMB_CPU)-1:0] wr_src_i,
  input  logic [$clog2(N_NUMB_CPU)-1:0] wr_dst_i,
  input  logic [W_WIDTH_SYS-1:0]        wr_data_i,
  input  logic                          req_i,
  input  logic [WIDTH_ADDR-1:0]         addr_r_i,
  input  logic [$clog2(N_NUMB_CPU)-1:0] numb_r_cpu_i,
  output logic [W_WIDTH_SYS-1:0]        rdata_r_o,
  output logic                          err_r_o,
  output logic [N_NUMB_CPU-1:0]         ack_r_o,
  output logic [N_NUMB_CPU-1:0]         irq_o
);

  localparam int CPU_W = $clog2(N_NUMB_CPU);
  localparam int QW    = 2 * CPU_W;
  localparam int NQ    = N_NUMB_CPU * N_NUMB_CPU;
  localparam int HCW   = $clog2(HOLD_CYC + 1);

  logic [NQ-1:0]          q_full;
  logic [NQ-1:0]          q_empty;
  logic [NQ-1:0]          q_push;
  logic [NQ-1:0]          q_pop;
  logic [W_WIDTH_SYS-1:0] q_head [NQ];

  logic [31:0]            wr_q32;
  logic [QW-1:0]          wr_q;
  logic [31:0]            addr32;
  logic [31:0]            off32;
  region_e                dec_region;
  logic                   dec_err;

  rd_state_e              state;
  logic [HCW-1:0]         hold_cnt;
  region_e                region_p1;
  logic [QW-1:0]          idx_p1;
  logic [CPU_W-1:0]       cpu_p1;
  logic                   err_p1;
  logic                   pop_en;
  logic [W_WIDTH_SYS-1:0] rd_val;
  logic [N_NUMB_CPU-1:0]  irq_nxt;
  logic                   unused_hi;

  assign wr_q32    = q_index(32'(wr_dst_i), 32'(wr_src_i), N_NUMB_CPU);
  assign wr_q      = wr_q32[QW-1:0];
  assign addr32    = 32'(addr_r_i);
  assign unused_hi = ^{wr_q32[31:QW], off32[31:QW]};

  assign pop_en = (state == ST_RESP) && (region_p1 == REG_POP) && !err_p1;

  for (genvar g = 0; g < NQ; g++) begin : g_q
    assign q_push[g] = wr_valid_i && wr_ready_o && (wr_q == QW'(g));
    assign q_pop[g]  = pop_en && (idx_p1 == QW'(g));

    mbox_fifo_ctrl #(
      .DEPTH      (DEPTH),
      .W_WIDTH_SYS(W_WIDTH_SYS)
    ) u_fifo (
      .clk    (clk),
      .rstn   (rstn),
      .push   (q_push[g]),
      .pop    (q_pop[g]),
      .wr_data(wr_data_i),
      .rd_data(q_head[g]),
      .full   (q_full[g]),
      .empty  (q_empty[g])
    );
  end

`ifdef MBOX_DROP_CNT_EN
  logic [W_WIDTH_SYS-1:0] drop_cnt [N_NUMB_CPU];
  logic                   drop_inc;
  logic                   drop_clr;

  assign wr_ready_o = 1'b1;
  assign drop_inc   = wr_valid_i && q_full[wr_q];
  assign drop_clr   = (state == ST_RESP) && (region_p1 == REG_DROP) && !err_p1;

  // A drop landing on the clearing read survives as a count of one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < N_NUMB_CPU; k++)
        drop_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < N_NUMB_CPU; k++) begin
        if (drop_inc && (wr_src_i == CPU_W'(k)) && drop_clr && (idx_p1[CPU_W-1:0] == CPU_W'(k)))
          drop_cnt[k] <= W_WIDTH_SYS'(1);
        else if (drop_clr && (idx_p1[CPU_W-1:0] == CPU_W'(k)))
          drop_cnt[k] <= '0;
        else if (drop_inc && (wr_src_i == CPU_W'(k)) && (drop_cnt[k] != '1))
          drop_cnt[k] <= drop_cnt[k] + 1'b1;
      end
    end
  end
`else
  assign wr_ready_o = ~q_full[wr_q];
`endif

  always_comb begin
    dec_region = addr_region(addr32, N_NUMB_CPU);
    off32      = addr_offset(addr32, N_NUMB_CPU);
    dec_err    = 1'b0;
    case (dec_region)
      REG_POP: dec_err = (off32[QW-1:CPU_W] != numb_r_cpu_i) || q_empty[off32[QW-1:0]];
      REG_BAD: dec_err = 1'b1;
      default: dec_err = 1'b0;
    endcase
  end

  // ---- decode -> response stage boundary
  always_ff @(posedge clk) begin
    if (state == ST_DECODE) begin
      region_p1 <= dec_region;
      idx_p1    <= off32[QW-1:0];
      cpu_p1    <= numb_r_cpu_i;
    end
  end

  always_comb begin
    rd_val = '0;
    case (region_p1)
      REG_POP:    rd_val = q_head[idx_p1];
      REG_STATUS: rd_val[N_NUMB_CPU-1:0] = ~q_empty[{idx_p1[CPU_W-1:0], {CPU_W{1'b0}}} +: N_NUMB_CPU];
`ifdef MBOX_DROP_CNT_EN
      REG_DROP:   rd_val = drop_cnt[idx_p1[CPU_W-1:0]];
`endif
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      err_p1    <= 1'b0;
      ack_r_o   <= '0;
      err_r_o   <= 1'b0;
      rdata_r_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_i)
            state <= ST_DECODE;
        end
        ST_DECODE: begin
          err_p1 <= dec_err;
          state  <= ST_RESP;
        end
        ST_RESP: begin
          rdata_r_o <= err_p1 ? '0 : rd_val;
          err_r_o   <= err_p1;
          ack_r_o   <= {{(N_NUMB_CPU-1){1'b0}}, 1'b1} << cpu_p1;
          hold_cnt  <= '0;
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          // Ack is released after the hold window; requester must drop req before the next access.
          if (hold_cnt == HCW'(HOLD_CYC)) begin
            ack_r_o <= '0;
            err_r_o <= 1'b0;
            if (!req_i)
              state <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < N_NUMB_CPU; k++)
      irq_nxt[k] = ~&q_empty[k*N_NUMB_CPU +: N_NUMB_CPU];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      irq_o <= '0;
    else
      irq_o <= irq_nxt;
  end

endmodule

// File: tb/tb_mbox_queue_hub.sv
// Scenario bench for mbox_queue_hub with per-queue scoreboard of expected pop data.
module tb_mbox_queue_hub;

  localparam int N = 4, DEPTH = 4, W = 32, AW = 8, HOLD = 3;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          wr_valid_i = 1'b0;
  logic          wr_ready_o;
  logic [1:0]    wr_src_i = '0, wr_dst_i = '0;
  logic [W-1:0]  wr_data_i = '0;
  logic          req_i = 1'b0;
  logic [AW-1:0] addr_r_i = '0;
  logic [1:0]    numb_r_cpu_i = '0;
  logic [W-1:0]  rdata_r_o;
  logic          err_r_o;
  logic [N-1:0]  ack_r_o;
  logic [N-1:0]  irq_o;

  int total = 0;
  int bad = 0;
  logic [31:0] sb [16][$];
  int exp_drop [4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  mbox_queue_hub #(
    .N_NUMB_CPU(N), .DEPTH(DEPTH), .W_WIDTH_SYS(W), .WIDTH_ADDR(AW), .HOLD_CYC(HOLD)
  ) dut (
    .clk(clk), .rstn(rstn),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .wr_src_i(wr_src_i), .wr_dst_i(wr_dst_i), .wr_data_i(wr_data_i),
    .req_i(req_i), .addr_r_i(addr_r_i), .numb_r_cpu_i(numb_r_cpu_i),
    .rdata_r_o(rdata_r_o), .err_r_o(err_r_o), .ack_r_o(ack_r_o), .irq_o(irq_o)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called just after a negedge; returns just after a negedge once the accept edge passed.
  task automatic do_push(input logic [1:0] src, input logic [1:0] dst, input logic [31:0] d);
    int n, q;
    q = int'(dst) * N + int'(src);
    wr_valid_i = 1'b1; wr_src_i = src; wr_dst_i = dst; wr_data_i = d;
    #1;
    n = 0;
    while (wr_ready_o !== 1'b1 && n < 50) begin @(posedge clk); @(negedge clk); n++; end
    total++;
    if (wr_ready_o !== 1'b1) begin
      bad++; $display("FAIL push_ready_timeout: got %b expected 1", wr_ready_o);
    end else begin
`ifdef MBOX_DROP_CNT_EN
      if (sb[q].size() == DEPTH) exp_drop[src] = exp_drop[src] + 1;
      else sb[q].push_back(d);
`else
      sb[q].push_back(d);
`endif
      @(posedge clk); @(negedge clk);
    end
    wr_valid_i = 1'b0;
  endtask

  // Issues one bus access; reports captured response, ack latency in edges and ack high time.
  task automatic do_read(input logic [7:0] addr, input logic [1:0] cpu,
                         output logic [31:0] d, output logic e, output logic [3:0] a,
                         output int lat, output int hold);
    req_i = 1'b1; addr_r_i = addr; numb_r_cpu_i = cpu;
    lat = 0; hold = 0;
    do begin @(posedge clk); @(negedge clk); lat++; end while (ack_r_o == '0 && lat < 20);
    d = rdata_r_o; e = err_r_o; a = ack_r_o;
    req_i = 1'b0;
    total++;
    if (ack_r_o == '0) begin
      bad++; $display("FAIL read_ack_timeout: got %b expected nonzero", ack_r_o);
      return;
    end
    hold = 1;
    while (ack_r_o != '0 && hold < 40) begin
      @(posedge clk); @(negedge clk);
      if (ack_r_o != '0) hold++;
    end
  endtask

  task automatic test_reset();
    #2 rstn = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (ack_r_o !== 4'b0) begin bad++; $display("FAIL reset_ack: got %b expected 0000", ack_r_o); end
    total++; if (err_r_o !== 1'b0) begin bad++; $display("FAIL reset_err: got %b expected 0", err_r_o); end
    total++; if (irq_o !== 4'b0) begin bad++; $display("FAIL reset_irq: got %b expected 0000", irq_o); end
    total++; if (rdata_r_o !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h expected 0", rdata_r_o); end
    rstn = 1'b1;
    @(negedge clk);
    total++; if (wr_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b expected 1", wr_ready_o); end
  endtask

  task automatic test_basic();
    logic [31:0] d, exp; logic e; logic [3:0] a; int lat, hold;
    do_push(2'd1, 2'd2, 32'hA5A5_0001);
    @(posedge clk); @(negedge clk);
    total++; if (irq_o !== 4'b0100) begin bad++; $display("FAIL basic_irq_rise: got %b expected 0100", irq_o); end
    exp = sb[9].pop_front();
    do_read(8'd9, 2'd2, d, e, a, lat, hold);
    total++; if (lat !== 3) begin bad++; $display("FAIL basic_latency: got %0d expected 3", lat); end
    total++; if (a !== 4'b0100) begin bad++; $display("FAIL basic_ack: got %b expected 0100", a); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL basic_err: got %b expected 0", e); end
    total++; if (d !== exp) begin bad++; $display("FAIL basic_rdata: got %h expected %h", d, exp); end
    total++; if (hold !== HOLD + 1) begin bad++; $display("FAIL basic_ack_len: got %0d expected %0d", hold, HOLD + 1); end
    total++; if (irq_o !== 4'b0000) begin bad++; $display("FAIL basic_irq_fall: got %b expected 0000", irq_o); end
  endtask

  task automatic test_full_queue();
    logic [31:0] d, exp; logic e; logic [3:0] a; int lat, hold;
    for (int i = 1; i <= 4; i++) do_push(2'd0, 2'd3, 32'(i));
`ifdef MBOX_DROP_CNT_EN
    do_push(2'd0, 2'd3, 32'd5);
    do_read(8'd20, 2'd1, d, e, a, lat, hold);
    total++; if (d !== 32'(exp_drop[0]) || exp_drop[0] != 1) begin bad++; $display("FAIL drop_cnt_first: got %h expected %h", d, 32'd1); end
    exp_drop[0] = 0;
    do_read(8'd20, 2'd1, d, e, a, lat, hold);
    total++; if (d !== 32'(exp_drop[0])) begin bad++; $display("FAIL drop_cnt_cleared: got %h expected %h", d, 32'(exp_drop[0])); end
    for (int i = 0; i < 4; i++) begin
      exp = sb[12].pop_front();
      do_read(8'd12, 2'd3, d, e, a, lat, hold);
      total++; if (d !== exp || e !== 1'b0) begin bad++; $display("FAIL drain_pop: got %h err %b expected %h err 0", d, e, exp); end
    end
`else
    wr_valid_i = 1'b1; wr_src_i = 2'd0; wr_dst_i = 2'd3; wr_data_i = 32'd5;
    #1;
    total++; if (wr_ready_o !== 1'b0) begin bad++; $display("FAIL bp_ready_full: got %b expected 0", wr_ready_o); end
    repeat (3) @(negedge clk);
    total++; if (wr_ready_o !== 1'b0) begin bad++; $display("FAIL bp_ready_stall: got %b expected 0", wr_ready_o); end
    exp = sb[12].pop_front();
    fork
      do_push(2'd0, 2'd3, 32'd5);
      do_read(8'd12, 2'd3, d, e, a, lat, hold);
    join
    total++; if (d !== exp) begin bad++; $display("FAIL bp_first_pop: got %h expected %h", d, exp); end
    for (int i = 0; i < 4; i++) begin
      exp = sb[12].pop_front();
      do_read(8'd12, 2'd3, d, e, a, lat, hold);
      total++; if (d !== exp || e !== 1'b0) begin bad++; $display("FAIL bp_pop_order: got %h err %b expected %h err 0", d, e, exp); end
    end
    do_read(8'd20, 2'd0, d, e, a, lat, hold);
    total++; if (d !== 32'h0 || e !== 1'b0) begin bad++; $display("FAIL drop_cnt_absent: got %h err %b expected 0 err 0", d, e); end
`endif
    do_read(8'd19, 2'd3, d, e, a, lat, hold);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL full_status_empty: got %h expected 0", d); end
  endtask

  task automatic test_non_owner();
    logic [31:0] d, exp; logic e; logic [3:0] a; int lat, hold;
    do_push(2'd1, 2'd2, 32'h0000_0011);
    do_read(8'd9, 2'd0, d, e, a, lat, hold);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL owner_err: got %b expected 1", e); end
    total++; if (a !== 4'b0001) begin bad++; $display("FAIL owner_ack: got %b expected 0001", a); end
    total++; if (d !== 32'h0) begin bad++; $display("FAIL owner_rdata: got %h expected 0", d); end
    do_read(8'd18, 2'd0, d, e, a, lat, hold);
    total++; if (d !== 32'h2 || e !== 1'b0) begin bad++; $display("FAIL owner_status: got %h err %b expected 2 err 0", d, e); end
    exp = sb[9].pop_front();
    do_read(8'd9, 2'd2, d, e, a, lat, hold);
    total++; if (d !== exp || e !== 1'b0) begin bad++; $display("FAIL owner_pop: got %h err %b expected %h err 0", d, e, exp); end
  endtask

  task automatic test_errors();
    logic [31:0] d; logic e; logic [3:0] a; int lat, hold;
    do_read(8'd5, 2'd1, d, e, a, lat, hold);
    total++; if (e !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL empty_pop: got err %b data %h expected err 1 data 0", e, d); end
    do_read(8'hFF, 2'd2, d, e, a, lat, hold);
    total++; if (e !== 1'b1 || d !== 32'h0 || a !== 4'b0100) begin bad++; $display("FAIL bad_addr_ff: got err %b data %h ack %b expected err 1 data 0 ack 0100", e, d, a); end
    do_read(8'd24, 2'd0, d, e, a, lat, hold);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL bad_addr_24: got %b expected 1", e); end
  endtask

  task automatic test_push_pop_same();
    logic [31:0] d, exp; logic e; logic [3:0] a; int lat, hold;
    do_push(2'd1, 2'd2, 32'hAAAA_0001);
    do_push(2'd1, 2'd2, 32'hAAAA_0002);
    exp = sb[9].pop_front();
    fork
      do_read(8'd9, 2'd2, d, e, a, lat, hold);
      begin
        @(posedge clk); @(posedge clk); @(negedge clk);
        do_push(2'd1, 2'd2, 32'hAAAA_0003);
      end
    join
    total++; if (d !== exp) begin bad++; $display("FAIL same_cycle_pop: got %h expected %h", d, exp); end
    for (int i = 0; i < 2; i++) begin
      exp = sb[9].pop_front();
      do_read(8'd9, 2'd2, d, e, a, lat, hold);
      total++; if (d !== exp || e !== 1'b0) begin bad++; $display("FAIL same_cycle_order: got %h err %b expected %h err 0", d, e, exp); end
    end
    do_read(8'd9, 2'd2, d, e, a, lat, hold);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL same_cycle_count: got err %b expected 1", e); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic e; logic [3:0] a; int lat, hold, n;
    for (int i = 0; i < 3; i++) do_push(2'd0, 2'd3, 32'hC0DE_0000 + 32'(i + 1));
    req_i = 1'b1; addr_r_i = 8'd12; numb_r_cpu_i = 2'd3; n = 0;
    do begin @(posedge clk); @(negedge clk); n++; end while (ack_r_o == '0 && n < 20);
    total++; if (ack_r_o !== 4'b1000) begin bad++; $display("FAIL rst_mid_ack: got %b expected 1000", ack_r_o); end
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    total++; if (ack_r_o !== 4'b0) begin bad++; $display("FAIL rst_mid_ack_drop: got %b expected 0000", ack_r_o); end
    total++; if (irq_o !== 4'b0) begin bad++; $display("FAIL rst_mid_irq: got %b expected 0000", irq_o); end
    total++; if (rdata_r_o !== 32'h0 || err_r_o !== 1'b0) begin bad++; $display("FAIL rst_mid_rdata: got %h err %b expected 0 err 0", rdata_r_o, err_r_o); end
    req_i = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    sb[12].delete();
    @(negedge clk);
    do_read(8'd19, 2'd3, d, e, a, lat, hold);
    total++; if (d !== 32'h0 || e !== 1'b0) begin bad++; $display("FAIL rst_mid_status: got %h err %b expected 0 err 0", d, e); end
    do_read(8'd12, 2'd3, d, e, a, lat, hold);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL rst_mid_queue_lost: got err %b expected 1", e); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_queue();
    test_non_owner();
    test_errors();
    test_push_pop_same();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
